axi_ram_initiator: RTL and testbench

//  Master-side driver for the AXI-Stream byte RAM. Issues write commands as {16'b0, data, addr} on m_axis.

---
 rtl/axi_ram_initiator.sv | 190 +++++++++++++++++++
 tb/tb_axi_ram_initiator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_initiator.sv
// Command sequencer for the AXI-Stream byte RAM: issues one write per word, checks
// each echoed byte, and aborts the job when a response does not arrive in time.
module axi_ram_initiator #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [8:0]        num_words,
    input  logic [DATA_W-1:0] data_seed,
    output logic              busy,
    output logic              done,
    output logic [8:0]        err_count,
    output logic              timeout,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W     = $clog2(TIMEOUT);
    localparam int PAD_W     = 32 - ADDR_W - DATA_W;
    localparam int RSP_PAD_W = 32 - DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q,   state_d;
    logic [8:0]        idx_q,     idx_d;
    logic [8:0]        last_q,    last_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [8:0]        err_q,     err_d;
    logic              timeout_q, timeout_d;
    logic              mvalid_q,  mvalid_d;
    logic [31:0]       mdata_q,   mdata_d;
    logic              sready_q,  sready_d;

    logic [ADDR_W-1:0] nextAddr;
    logic [DATA_W-1:0] nextData;
    logic              rspHit;
    logic              rspOk;

    function automatic logic [31:0] makeCmd(input logic [DATA_W-1:0] d,
                                            input logic [ADDR_W-1:0] a);
        return {{PAD_W{1'b0}}, d, a};
    endfunction

    assign nextAddr = addr_q + 1'b1;
    assign nextData = data_q + 1'b1;
    assign rspHit   = s_axis_tvalid && sready_q;
    assign rspOk    = (s_axis_tdata == {{RSP_PAD_W{1'b0}}, data_q});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        timeout_d = timeout_q;
        mvalid_d  = mvalid_q;
        mdata_d   = mdata_q;
        sready_d  = sready_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d     = 9'd0;
                    timeout_d = 1'b0;
                    if (num_words != 9'd0) begin
                        addr_d   = base_addr;
                        data_d   = data_seed;
                        idx_d    = 9'd0;
                        last_d   = num_words - 9'd1;
                        busy_d   = 1'b1;
                        mvalid_d = 1'b1;
                        mdata_d  = makeCmd(data_seed, base_addr);
                        state_d  = S_SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_SEND: begin
                if (m_axis_tready) begin
                    mvalid_d = 1'b0;
                    sready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end
            end

            // A response landing on the final timeout cycle wins over the abort.
            S_WAIT: begin
                if (rspHit) begin
                    sready_d = 1'b0;
                    if (!rspOk) begin
                        err_d = err_q + 9'd1;
                    end
                    if (idx_q == last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d    = idx_q + 9'd1;
                        addr_d   = nextAddr;
                        data_d   = nextData;
                        mvalid_d = 1'b1;
                        mdata_d  = makeCmd(nextData, nextAddr);
                        state_d  = S_SEND;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    sready_d  = 1'b0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            idx_q     <= 9'd0;
            last_q    <= 9'd0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 9'd0;
            timeout_q <= 1'b0;
            mvalid_q  <= 1'b0;
            mdata_q   <= 32'd0;
            sready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            mvalid_q  <= mvalid_d;
            mdata_q   <= mdata_d;
            sready_q  <= sready_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_q;
    assign timeout       = timeout_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tdata  = mdata_q;
    assign s_axis_tready = sready_q;

endmodule

// File: tb/tb_axi_ram_initiator.sv
// Directed bench for axi_ram_initiator: a scoreboard of expected commands plus a
// configurable echo responder (stall, corrupt, silent) running on the falling edge.
module tb_axi_ram_initiator;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic [8:0]  num_words = 9'd0;
    logic [7:0]  data_seed = 8'd0;
    logic        busy;
    logic        done;
    logic [8:0]  err_count;
    logic        timeout;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sb[$];
    logic [31:0] expCmd;
    logic [31:0] heldData = 32'd0;
    logic [7:0]  rspData = 8'd0;
    logic        rspFired = 1'b0;
    logic        stalling = 1'b0;

    int stallWord = -1;
    int stallLeft = 0;
    int badWord = -1;
    int silentFrom = 1000;
    int beatCount = 0;
    int rspIdx = 0;
    int doneCount = 0;
    int waitCnt = 0;

    axi_ram_initiator #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(64)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .data_seed     (data_seed),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .timeout       (timeout),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Everything here decides what happens at the next rising edge.
    always @(negedge aclk) begin
        if (done === 1'b1) doneCount++;
        checkOutput("tvalid_sready_exclusive", 32'(m_tvalid & s_tready), 32'd0);
        if (rspFired) begin
            s_tvalid = 1'b0;
            s_tdata  = 32'd0;
            rspFired = 1'b0;
        end
        if (m_tvalid === 1'b1) begin
            if (beatCount == stallWord && stallLeft > 0) begin
                if (!stalling) begin
                    heldData = m_tdata;
                    stalling = 1'b1;
                end else begin
                    checkOutput("stall_tdata", m_tdata, heldData);
                end
                m_tready = 1'b0;
                stallLeft--;
            end else begin
                if (stalling) checkOutput("stall_tdata", m_tdata, heldData);
                stalling = 1'b0;
                m_tready = 1'b1;
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    expCmd = sb.pop_front();
                    checkOutput("cmd", m_tdata, expCmd);
                    rspData = expCmd[15:8];
                end
                beatCount++;
            end
        end else begin
            if (stalling) checkOutput("stall_tvalid", 32'(m_tvalid), 32'd1);
            stalling = 1'b0;
            m_tready = 1'b0;
        end
        if (s_tready === 1'b1 && !s_tvalid && rspIdx < silentFrom) begin
            if (waitCnt < 1) begin
                waitCnt++;
            end else begin
                waitCnt  = 0;
                s_tvalid = 1'b1;
                s_tdata  = (rspIdx == badWord) ? 32'h0000_0055 : {24'd0, rspData};
                rspIdx++;
            end
        end
        if (s_tvalid && s_tready === 1'b1) rspFired = 1'b1;
    end

    task automatic applyStimulus(input logic [7:0] b, input logic [8:0] n, input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] d;
        @(negedge aclk);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        data_seed = s;
        beatCount = 0;
        rspIdx    = 0;
        waitCnt   = 0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            d = s + 8'(i);
            sb.push_back({16'h0000, d, a});
        end
        @(negedge aclk);
        start     = 1'b0;
        base_addr = ~b;
        num_words = 9'h1AA;
        data_seed = 8'h5A;
    endtask

    task automatic waitDone(input int budget);
        int cycles;
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge aclk);
            cycles++;
        end
        if (done !== 1'b1) checkOutput("done_wait_expired", 32'(done), 32'd1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        checkOutput({tag, "_tdata"}, m_tdata, 32'd0);
        checkOutput({tag, "_sready"}, 32'(s_tready), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) @(negedge aclk);
        checkIdleOutputs("reset");
        areset = 1'b0;

        // Basic four-word job with 1-cycle responder lag.
        d0 = doneCount;
        applyStimulus(8'h10, 9'd4, 8'hA0);
        checkOutput("t1_first_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        waitDone(100);
        checkOutput("t1_err", 32'(err_count), 32'd0);
        checkOutput("t1_busy_at_done", 32'(busy), 32'd0);
        checkOutput("t1_beats", 32'(beatCount), 32'd4);
        checkOutput("t1_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge aclk);
        checkOutput("t1_done_one_cycle", 32'(done), 32'd0);
        @(negedge aclk);
        checkOutput("t1_done_count", 32'(doneCount - d0), 32'd1);

        // Address and data wrap.
        applyStimulus(8'hFE, 9'd3, 8'hFF);
        waitDone(100);
        checkOutput("t2_err", 32'(err_count), 32'd0);
        checkOutput("t2_beats", 32'(beatCount), 32'd3);
        checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure on word 1.
        stallWord = 1;
        stallLeft = 5;
        applyStimulus(8'h20, 9'd4, 8'h33);
        waitDone(100);
        checkOutput("t3_stall_consumed", 32'(stallLeft), 32'd0);
        checkOutput("t3_beats", 32'(beatCount), 32'd4);
        checkOutput("t3_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("t3_err", 32'(err_count), 32'd0);
        stallWord = -1;

        // Corrupted response for word 2.
        badWord = 2;
        @(negedge aclk);
        d0 = doneCount;
        applyStimulus(8'h60, 9'd4, 8'h30);
        waitDone(100);
        checkOutput("t4_err", 32'(err_count), 32'd1);
        checkOutput("t4_beats", 32'(beatCount), 32'd4);
        @(negedge aclk);
        @(negedge aclk);
        checkOutput("t4_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("t4_err_held", 32'(err_count), 32'd1);
        badWord = -1;

        // Silent responder: abort after TIMEOUT cycles in WAIT_RSP.
        silentFrom = 0;
        applyStimulus(8'h40, 9'd2, 8'h00);
        n = 0;
        while (s_tready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("t5_sready_seen", 32'(s_tready), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("t5_timeout_latency", 32'(n), 32'd64);
        checkOutput("t5_timeout", 32'(timeout), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_sready", 32'(s_tready), 32'd0);
        checkOutput("t5_err", 32'(err_count), 32'd0);
        checkOutput("t5_unsent_words", 32'(sb.size()), 32'd1);
        sb.delete();
        silentFrom = 1000;
        applyStimulus(8'h41, 9'd1, 8'h07);
        checkOutput("t5_timeout_cleared", 32'(timeout), 32'd0);
        waitDone(100);
        checkOutput("t5_retry_timeout", 32'(timeout), 32'd0);
        checkOutput("t5_retry_err", 32'(err_count), 32'd0);

        // Reset during WAIT_RSP of word 1, then an empty job.
        silentFrom = 1;
        applyStimulus(8'h80, 9'd3, 8'h11);
        n = 0;
        while (!(beatCount == 2 && s_tready === 1'b1) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("t6_in_wait_word1", 32'(s_tready), 32'd1);
        d0 = doneCount;
        areset = 1'b1;
        @(negedge aclk);
        checkIdleOutputs("t6_reset");
        areset = 1'b0;
        sb.delete();
        repeat (3) @(negedge aclk);
        checkOutput("t6_no_done", 32'(doneCount - d0), 32'd0);
        silentFrom = 1000;
        applyStimulus(8'h00, 9'd0, 8'h99);
        checkOutput("t6_empty_done", 32'(done), 32'd1);
        checkOutput("t6_empty_busy", 32'(busy), 32'd0);
        checkOutput("t6_empty_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge aclk);
        checkOutput("t6_empty_done_drop", 32'(done), 32'd0);
        checkOutput("t6_empty_beats", 32'(beatCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
